// File: rtl/show_pkg.sv
// show_pkg: shared types and constants for the seven-segment display scheduler.
//   state_t  : IDLE / SHOW / PIN arbitration states
//   DIGIT_W  : width of one display digit nibble
//   VALUE_W  : width of one source value (four digits)
//   IDX_W    : width of a source index (up to four sources)
//   cnt_w()  : counter width for a modulus (dwell and scan counters)
package show_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    PIN  = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;
  localparam int VALUE_W = 16;
  localparam int IDX_W   = 2;

  // Width needed to count 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/show_rr_pick.sv
// show_rr_pick: combinational round-robin next-candidate finder.
//   req   : per-source request vector
//   ptr   : index of the last granted source
//   idx   : first requesting index found searching ptr+1, ptr+2, ... ptr
//   found : at least one source is requesting
module show_rr_pick
  import show_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  function automatic logic [IDX_W-1:0] wrap(input int v);
    return IDX_W'(v % N_SRC);
  endfunction

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    idx   = '0;
    found = 1'b0;
    // Walk from the farthest position (ptr itself) to the nearest (ptr+1);
    // the last hit written is the nearest, so no early exit is needed.
    for (int k = N_SRC; k >= 1; k--) begin
      if (req[wrap(int'(ptr) + k)]) begin
        idx   = wrap(int'(ptr) + k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/show_arbiter.sv
// show_arbiter: shares the 4-digit seven-segment display between up to four
// 16-bit sources. Round-robin grant with a fixed dwell, manual pin override,
// registered digit nibbles and a free-running scan clock enable.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : per-source level request
//   data         : source i value at data[16i+15:16i]
//   pin_en       : manual override enable
//   pin_sel      : source index to pin
//   grant        : one-hot displayed source, 0 when idle
//   active       : grant is non-zero
//   num1..num4   : digit nibbles, num1 rightmost
//   scan_tick    : one-cycle pulse every SCAN_DIV cycles
module show_arbiter
  import show_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int DWELL    = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC-1:0]         req,
  input  logic [VALUE_W*N_SRC-1:0] data,
  input  logic                     pin_en,
  input  logic [1:0]               pin_sel,
  output logic [N_SRC-1:0]         grant,
  output logic                     active,
  output logic [DIGIT_W-1:0]       num1,
  output logic [DIGIT_W-1:0]       num2,
  output logic [DIGIT_W-1:0]       num3,
  output logic [DIGIT_W-1:0]       num4,
  output logic                     scan_tick
);

  localparam int DW_W = cnt_w(DWELL);
  localparam int SC_W = cnt_w(SCAN_DIV);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [DW_W-1:0]    dwell;
  logic [VALUE_W-1:0] shown;
  logic [SC_W-1:0]    scan_cnt;

  // Per-source value view of the packed data bus.
  logic [VALUE_W-1:0] src [N_SRC];
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign src[i] = data[VALUE_W*i +: VALUE_W];
  end

  // On leaving PIN the search starts from the pinned source, otherwise from
  // the last granted source.
  logic [IDX_W-1:0] pick_base;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  assign pick_base = (state == PIN) ? pin_sel : ptr;

  show_rr_pick #(
    .N_SRC(N_SRC)
  ) u_pick (
    .req  (req),
    .ptr  (pick_base),
    .idx  (pick_idx),
    .found(pick_found)
  );

  logic dwell_done;
  assign dwell_done = (dwell == DW_W'(DWELL - 1));

  // Arbitration state machine; grant and displayed value are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= IDX_W'(N_SRC - 1);
      dwell <= '0;
      grant <= '0;
      // NOTE: the displayed value is an ordinary register, not a memory, so it
      // is reset with everything else and the digits read 0 straight away.
      shown <= '0;
    end else if (pin_en) begin
      state <= PIN;
      dwell <= '0;
      grant <= N_SRC'(1) << pin_sel;
      shown <= src[pin_sel];
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            state <= SHOW;
            ptr   <= pick_idx;
            dwell <= '0;
            grant <= N_SRC'(1) << pick_idx;
            shown <= src[pick_idx];
          end else begin
            grant <= '0;
            shown <= '0;
          end
        end

        SHOW: begin
          // A dropped request wins over dwell expiry; both rotate the same way.
          if (!req[ptr] || dwell_done) begin
            dwell <= '0;
            if (pick_found) begin
              ptr   <= pick_idx;
              grant <= N_SRC'(1) << pick_idx;
              shown <= src[pick_idx];
            end else begin
              state <= IDLE;
              grant <= '0;
              shown <= '0;
            end
          end else begin
            dwell <= dwell + DW_W'(1);
            shown <= src[ptr];
          end
        end

        PIN: begin
          dwell <= '0;
          if (req[pin_sel]) begin
            state <= SHOW;
            ptr   <= pin_sel;
            grant <= N_SRC'(1) << pin_sel;
            shown <= src[pin_sel];
          end else if (pick_found) begin
            state <= SHOW;
            ptr   <= pick_idx;
            grant <= N_SRC'(1) << pick_idx;
            shown <= src[pick_idx];
          end else begin
            state <= IDLE;
            ptr   <= pin_sel;
            grant <= '0;
            shown <= '0;
          end
        end

        default: begin
          state <= IDLE;
          grant <= '0;
          shown <= '0;
        end
      endcase
    end
  end

  // Free-running scan divider. The pulse is registered one count early so it
  // is high in the cycle where the counter holds SCAN_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      scan_tick <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      scan_cnt  <= (scan_cnt == SC_W'(SCAN_DIV - 1)) ? '0 : scan_cnt + SC_W'(1);
      scan_tick <= (scan_cnt == SC_W'(SCAN_DIV - 2));
    end
  end

  assign active = |grant;
  assign num1   = shown[3:0];
  assign num2   = shown[7:4];
  assign num3   = shown[11:8];
  assign num4   = shown[15:12];

endmodule

// File: tb/tb_show_arbiter.sv
// tb_show_arbiter: directed and randomized checks of show_arbiter against a
// behavioural model of who is on the display and for how long.
module tb_show_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [N-1:0] req;
  logic [15:0] d [N];
  logic [63:0] data;
  logic        pin_en;
  logic [1:0]  pin_sel;
  logic [N-1:0] grant;
  logic        active;
  logic [3:0]  num1, num2, num3, num4;
  logic        scan_tick;

  assign data = {d[3], d[2], d[1], d[0]};

  show_arbiter #(
    .N_SRC   (N),
    .DWELL   (DW),
    .SCAN_DIV(SD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data     (data),
    .pin_en   (pin_en),
    .pin_sel  (pin_sel),
    .grant    (grant),
    .active   (active),
    .num1     (num1),
    .num2     (num2),
    .num3     (num3),
    .num4     (num4),
    .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: which source is on screen (-1 none), how long it has been there,
  // whether it is pinned, and the last source that was granted.
  int          m_cur, m_last, m_age, edges;
  bit          m_pinned;
  logic [15:0] m_val;

  function automatic int next_req(input int from);
    for (int k = 1; k <= N; k++) begin
      if (req[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_cur    = -1;
    m_last   = N - 1;
    m_age    = 0;
    m_pinned = 0;
    edges    = 0;
    m_val    = '0;
  endtask

  task automatic give(input int who);
    m_cur = who;
    m_age = 0;
    if (who >= 0) m_last = who;
  endtask

  task automatic model_step();
    if (pin_en) begin
      m_cur    = int'(pin_sel);
      m_pinned = 1;
      m_age    = 0;
    end else if (m_pinned) begin
      m_pinned = 0;
      m_last   = int'(pin_sel);
      if (req[pin_sel]) give(int'(pin_sel));
      else              give(next_req(m_last));
    end else if (m_cur < 0) begin
      give(next_req(m_last));
    end else if (!req[m_cur] || m_age == DW - 1) begin
      give(next_req(m_cur));
    end else begin
      m_age++;
    end
    m_val = (m_cur < 0) ? 16'h0 : d[m_cur];
    edges++;
  endtask

  task automatic cycle();
    logic [N-1:0] eg;
    @(posedge clk);
    model_step();
    @(negedge clk);
    eg = (m_cur < 0) ? '0 : N'(1) << m_cur;
    check("grant", 32'(grant), 32'(eg));
    check("active", 32'(active), 32'(eg != 0));
    check("num", 32'({num4, num3, num2, num1}), 32'(m_val));
    check("scan_tick", 32'(scan_tick), 32'((edges % SD) == SD - 1));
  endtask

  // Asserts reset between clock edges and checks the outputs clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst grant", 32'(grant), 32'h0);
    check("rst active", 32'(active), 32'h0);
    check("rst num", 32'({num4, num3, num2, num1}), 32'h0);
    check("rst scan_tick", 32'(scan_tick), 32'h0);
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b1;
    req     = '0;
    pin_en  = 1'b0;
    pin_sel = 2'd0;
    for (int i = 0; i < N; i++) d[i] = 16'h0;
    #1;
    do_reset();

    // Idle: nothing shown, scan tick every SD cycles.
    repeat (12) cycle();

    // Two requesters alternate every DW cycles.
    d[0] = 16'h1234;
    d[2] = 16'hBEEF;
    req  = 4'b0101;
    cycle();
    check("first grant", 32'(grant), 32'h1);
    check("first num", 32'({num4, num3, num2, num1}), 32'h1234);
    repeat (DW) cycle();
    check("rotate grant", 32'(grant), 32'h4);
    check("rotate num", 32'({num4, num3, num2, num1}), 32'hBEEF);
    repeat (DW) cycle();
    check("rotate back", 32'(grant), 32'h1);

    // Single requester is held across dwell expiries, then dropped.
    req = 4'b0010;
    repeat (30) cycle();
    check("single hold", 32'(grant), 32'h2);
    req = 4'b0000;
    cycle();
    check("single drop", 32'(grant), 32'h0);

    // Drop of the shown source mid-dwell switches at once with fresh dwell.
    req = 4'b0001;
    cycle();
    check("src0 shown", 32'(grant), 32'h1);
    req = 4'b1001;
    repeat (3) cycle();
    req = 4'b1000;
    cycle();
    check("drop switch", 32'(grant), 32'h8);
    req = 4'b1001;
    repeat (DW - 1) cycle();
    check("fresh dwell hold", 32'(grant), 32'h8);
    cycle();
    check("fresh dwell end", 32'(grant), 32'h1);

    // Pin override with no requests, data tracking, then release.
    req     = 4'b0000;
    pin_en  = 1'b1;
    pin_sel = 2'd2;
    cycle();
    check("pin grant", 32'(grant), 32'h4);
    for (int i = 0; i < 3; i++) begin
      d[2] = 16'($urandom);
      cycle();
    end
    req    = 4'b1001;
    pin_en = 1'b0;
    cycle();
    check("pin release", 32'(grant), 32'h8);

    // Reset in the middle of a dwell, then first grant is source 0 again.
    do_reset();
    req = 4'b1111;
    repeat (6) cycle();
    #2;
    do_reset();
    cycle();
    check("post-reset grant", 32'(grant), 32'h1);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0) req = N'($urandom);
      d[$urandom_range(N - 1)] = 16'($urandom);
      if ($urandom_range(39) == 0) pin_en = ~pin_en;
      if ($urandom_range(9) == 0) pin_sel = 2'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/show_arbiter.md
# show_arbiter

Scheduler that shares the 4-digit seven-segment display between up to four 16-bit sources, for example PC, the ALU result, a register value and a debug word. It grants the display to one requester at a time and rotates round-robin after a fixed dwell time. A manual pin input overrides the rotation. It drives the four digit nibbles and a scan-enable pulse into the existing digit-scan/7448-decode display block, which sits directly downstream.

## Interface
Parameters:
- N_SRC, 4: number of sources (2..4).
- DWELL, 50_000_000: cycles a source is held before rotation (≥2).
- SCAN_DIV, 50_000: period in cycles of scan_tick (≥2).

Ports:
- clk  in  1  system clock; everything sits in this one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_SRC  per-source display request, level-sensitive.
- data  in  16*N_SRC  source i value at data[16i+15:16i].
- pin_en  in  1  manual override enable (board switch, pre-synchronised).
- pin_sel  in  2  source index to pin; must be < N_SRC.
- grant  out  N_SRC  one-hot index of the displayed source; 0 when nothing is shown.
- active  out  1  grant is non-zero.
- num1..num4  out  4 each  digit nibbles; num1 = bits[3:0] (rightmost digit) … num4 = bits[15:12].
- scan_tick  out  1  one-cycle pulse every SCAN_DIV cycles; the clock enable for the scanner.

## Operation
States:
- IDLE: grant=0, num*=0.
- SHOW: one source granted; dwell counter running.
- PIN: pin_sel source granted unconditionally; dwell counter held at 0.

Round-robin pointer `ptr` holds the last granted index. The next candidate is the first i with req[i]=1, searching ptr+1, ptr+2, … with wrap modulo N_SRC. The search includes ptr itself last.

Transitions:
- IDLE → SHOW: when any req is set. Grant goes to the next candidate, ptr updates, and dwell clears.
- SHOW, dwell reaches DWELL-1: rotate to the next candidate.
  - If only the current source is requesting, it stays granted and dwell restarts.
- SHOW, req[current] falls: switch on the next edge to the next candidate, or go to IDLE if req=0. No dwell wait.
- Dwell expiry and req drop in the same cycle: treated as a drop. The result is the same.
- Any state, pin_en=1 → PIN; next edge grant=1<<pin_sel. A pin_sel change while in PIN takes effect on the next edge.
- PIN, pin_en=0: set ptr=pin_sel.
  - If req[pin_sel]=1, go to SHOW on the same source with a fresh dwell.
  - Otherwise arbitrate as from SHOW-drop.

Display data:
- num1..num4 are registered every cycle from the live data of the granted source, so values track the CPU continuously.
- In IDLE they are 0.

scan_tick comes from a free-running counter that is independent of the state machine and runs in all states.

## Timing
- Reset, asynchronous on rst_n low: state=IDLE, ptr=N_SRC-1 (so the first grant goes to source 0), dwell=0, grant=0, active=0, num1..num4=0, scan counter=0, scan_tick=0.
- Grant latency: a req edge sampled in IDLE gives grant/active on the next clock edge. num* update on that same edge with the granted source's data.
- Data latency: a data change appears on num* one cycle later.
- Dwell: a granted source stays displayed for exactly DWELL cycles when others are requesting.
- scan_tick: first pulse in cycle SCAN_DIV-1 after reset release, then every SCAN_DIV cycles.
- Reset mid-SHOW or mid-PIN: all outputs clear immediately. The first grant after release goes to source 0 again.
- grant is never multi-hot. active equals |grant.

## Structure
- Package show_pkg:
  - state enum {IDLE, SHOW, PIN}.
  - DIGIT_W=4 and VALUE_W=16.
  - Helper for the dwell and scan counter widths: $clog2 of DWELL and of SCAN_DIV.
- Sub-module show_rr_pick: combinational next-candidate finder.
  - Inputs: req and ptr.
  - Outputs: index and found.
- The state machine, dwell counter, scan divider and num registers live in show_arbiter.

## Test plan
Run with DWELL=8, SCAN_DIV=4, N_SRC=4 unless stated otherwise.
- Reset, req=0: grant=0, num*=0 throughout; scan_tick pulses in cycles 3, 7, 11, ….
- req=4'b0101, data0=16'h1234, data2=16'hBEEF: grant 0001 one cycle after req with num4..num1=1,2,3,4. After 8 cycles grant=0100 with num*=B,E,E,F. Grant then alternates every 8 cycles.
- req=4'b0010 only: grant=0010 held indefinitely with dwell restarting. Dropping req[1] gives grant=0 on the next edge.
- Source 0 shown; drop req[0] at dwell count 3 with req[3]=1: grant=1000 next edge with a fresh 8-cycle dwell.
- pin_en=1, pin_sel=2, req=0: grant=0100 and num* tracks data2. Releasing pin with req=4'b1001 grants source 3 (search from ptr=2).
- Assert rst_n=0 mid-SHOW at dwell count 5: all outputs become 0 asynchronously. After release with req=4'b1111, the first grant is 0001.
